stage_controller: RTL and testbench
===================================

Name: stage_controller

Overview:
Sequencing controller for the 2-bit stage data register (reset/clock/stageon/datain/dataout). It selects the active stage number and drives stageon low while the register must capture and high while it must hold. It also runs a per-stage countdown timer and advances through stages on clear events until all stages are won or a fail or timeout ends the game.

Parameters:
NUM_STAGES, 4, number of stages; stage_num runs 0..NUM_STAGES-1; legal range 1..4.
TIMER_W, 8, width of the stage countdown timer.
STAGE_TIME, 100, cycles allowed per stage; legal range 1..2^TIMER_W-1.
LOAD_CYCLES, 2, cycles stageon is held low with stage_num stable; minimum 2, to cover the register's one-cycle stageon delay.
CLEAR_HOLD, 4, cycles spent in CLEARED before advancing; minimum 1.

Ports:
clock  in  1  system clock; all state changes on the rising edge.
reset  in  1  asynchronous, active-low reset.
start  in  1  one-cycle pulse; begins or restarts a game.
stage_clear  in  1  current stage completed; sampled only in PLAY.
stage_fail  in  1  current stage failed; sampled only in PLAY.
stageon  out  1  to the stage register: 0 = capture datain, 1 = hold.
stage_num  out  2  stage number driven to the stage register's datain.
time_left  out  TIMER_W  remaining cycles in the current stage.
busy  out  1  high in LOAD, PLAY and CLEARED.
game_over  out  1  high in OVER.
game_win  out  1  high in WIN.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - stage_num=0, time_left=0, stageon=0, busy=0, game_over=0, game_win=0.
  - Takes effect immediately, including mid-PLAY; no pulse stored across reset.
- All outputs are registered or decoded from registered state only; no combinational input-to-output paths.
- States: IDLE, LOAD, PLAY, CLEARED, OVER, WIN.
- IDLE:
  - stageon=0.
  - start=1 -> LOAD, stage_num=0.
- LOAD:
  - stageon=0, stage_num stable.
  - Load counter runs LOAD_CYCLES cycles, then -> PLAY with time_left=STAGE_TIME.
  - start, clear and fail are ignored.
- PLAY:
  - stageon=1.
  - Per-cycle priority: stage_fail > stage_clear > timeout.
  - stage_fail=1 -> OVER; time_left frozen.
  - Else stage_clear=1 -> CLEARED; time_left frozen.
  - Else if time_left==1 -> OVER with time_left=0 (timeout).
  - Else time_left decrements by 1.
  - PLAY therefore lasts at most STAGE_TIME cycles.
  - A clear in the same cycle as time_left==1 counts as a clear.
- CLEARED:
  - stageon=1, held for CLEAR_HOLD cycles.
  - At the end: if stage_num==NUM_STAGES-1 -> WIN; else stage_num+1 and -> LOAD.
  - Inputs are ignored.
- OVER and WIN:
  - stageon=1, sticky; stage_num and time_left are held.
  - start=1 -> LOAD with stage_num=0 (restart).
- start is ignored in LOAD, PLAY and CLEARED.
- stage_num never exceeds NUM_STAGES-1; there is no wrap-around path.
- Arithmetic:
  - Timer is unsigned and never decrements below 0.
  - Load and hold counters are sized clog2(max(LOAD_CYCLES, CLEAR_HOLD)+1).
- Simultaneous start with clear or fail in PLAY: start is ignored and clear/fail processed.

Decomposition:
- Shared package stage_ctrl_pkg:
  - state encoding constants S_IDLE=0, S_LOAD=1, S_PLAY=2, S_CLEARED=3, S_OVER=4, S_WIN=5 (3 bits).
  - Default parameter constants.
- One sub-module stage_timer: a loadable down-counter.
  - Inputs: clock, reset, load, load_value, enable.
  - Outputs: count, is_one.
  - Instantiated once for time_left.
- The LOAD and CLEARED dwell counters stay inline in the FSM.

Test Plan:
1. Reset mid-PLAY (stage 2, time_left=57) with reset=0 -> all outputs zero and state IDLE immediately; after release, start gives LOAD with stage_num=0.
2. start, then clear on the 10th PLAY cycle of every stage, NUM_STAGES=4 -> stage_num 0,1,2,3; stageon low exactly 2 cycles per LOAD; game_win=1 after the 4th CLEARED hold.
3. start with no events, STAGE_TIME=100 -> stageon high 100 cycles; time_left 100..1 then 0; game_over=1; stage_num=0.
4. stage_clear and stage_fail both high in the same PLAY cycle -> OVER, game_over=1, time_left frozen at its current value.
5. stage_clear high exactly when time_left==1 -> CLEARED with time_left=1, not OVER.
6. start pulses during LOAD, PLAY and CLEARED -> no effect; start in OVER and in WIN -> LOAD with stage_num=0 and flags cleared.

Source files
------------

// File: rtl/stage_ctrl_pkg.sv
// stage_ctrl_pkg: shared state encoding and default parameters for the stage controller
package stage_ctrl_pkg;
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_PLAY    = 3'd2,
        S_CLEARED = 3'd3,
        S_OVER    = 3'd4,
        S_WIN     = 3'd5
    } state_t;
    localparam int DEF_NUM_STAGES  = 4;
    localparam int DEF_TIMER_W     = 8;
    localparam int DEF_STAGE_TIME  = 100;
    localparam int DEF_LOAD_CYCLES = 2;
    localparam int DEF_CLEAR_HOLD  = 4;
endpackage

// File: rtl/stage_timer.sv
// stage_timer: loadable down-counter that saturates at zero
module stage_timer #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         enable,
    output logic [W-1:0] count,
    output logic         is_one
);
    logic [W-1:0] count_q, count_d;
    always_comb count_d = load ? load_value : (enable && count_q != '0) ? count_q - 1'b1 : count_q;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) count_q <= '0;
        else        count_q <= count_d;
    end
    assign count  = count_q;
    assign is_one = count_q == W'(1);
endmodule

// File: rtl/stage_controller.sv
// stage_controller: stage sequencing FSM driving the stage register and a per-stage countdown
module stage_controller
    import stage_ctrl_pkg::*;
#(
    parameter int NUM_STAGES  = DEF_NUM_STAGES,
    parameter int TIMER_W     = DEF_TIMER_W,
    parameter int STAGE_TIME  = DEF_STAGE_TIME,
    parameter int LOAD_CYCLES = DEF_LOAD_CYCLES,
    parameter int CLEAR_HOLD  = DEF_CLEAR_HOLD
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               stage_clear,
    input  logic               stage_fail,
    output logic               stageon,
    output logic [1:0]         stage_num,
    output logic [TIMER_W-1:0] time_left,
    output logic               busy,
    output logic               game_over,
    output logic               game_win
);
    localparam int CW = $clog2((LOAD_CYCLES > CLEAR_HOLD ? LOAD_CYCLES : CLEAR_HOLD) + 1);
    localparam logic [CW-1:0] LOAD_LAST  = CW'(LOAD_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(CLEAR_HOLD - 1);
    localparam logic [1:0]    LAST_STAGE = 2'(NUM_STAGES - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    stage_q, stage_d;
    logic          tmr_load, tmr_en, tmr_one;

    // the timer is loaded on the last LOAD cycle so PLAY opens with a full STAGE_TIME
    stage_timer #(.W(TIMER_W)) u_timer (
        .clock      (clock),
        .reset      (reset),
        .load       (tmr_load),
        .load_value (TIMER_W'(STAGE_TIME)),
        .enable     (tmr_en),
        .count      (time_left),
        .is_one     (tmr_one)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stage_d  = stage_q;
        tmr_load = 1'b0;
        tmr_en   = state_q == S_PLAY && !stage_fail && !stage_clear;
        case (state_q)
            S_IDLE, S_OVER, S_WIN: begin
                if (start) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                    stage_d = '0;
                end
            end
            S_LOAD: begin
                if (cnt_q == LOAD_LAST) begin
                    state_d  = S_PLAY;
                    tmr_load = 1'b1;
                end else cnt_d = cnt_q + 1'b1;
            end
            S_PLAY: begin
                if (stage_fail) state_d = S_OVER;
                else if (stage_clear) begin
                    state_d = S_CLEARED;
                    cnt_d   = '0;
                end else if (tmr_one) state_d = S_OVER;
            end
            S_CLEARED: begin
                if (cnt_q != HOLD_LAST) cnt_d = cnt_q + 1'b1;
                else if (stage_q == LAST_STAGE) state_d = S_WIN;
                else begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                    stage_d = stage_q + 2'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            stage_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stage_q <= stage_d;
        end
    end

    assign stageon   = state_q inside {S_PLAY, S_CLEARED, S_OVER, S_WIN};
    assign busy      = state_q inside {S_LOAD, S_PLAY, S_CLEARED};
    assign game_over = state_q == S_OVER;
    assign game_win  = state_q == S_WIN;
    assign stage_num = stage_q;
endmodule

// File: tb/tb_stage_controller.sv
// tb_stage_controller: vector table plus model-driven scoreboard for stage_controller
module tb_stage_controller;
    import stage_ctrl_pkg::*;

    logic       clock = 1'b0, reset = 1'b0, start = 1'b0, stage_clear = 1'b0, stage_fail = 1'b0;
    logic       stageon, busy, game_over, game_win;
    logic [1:0] stage_num;
    logic [7:0] time_left;

    stage_controller dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .stage_clear (stage_clear),
        .stage_fail  (stage_fail),
        .stageon     (stageon),
        .stage_num   (stage_num),
        .time_left   (time_left),
        .busy        (busy),
        .game_over   (game_over),
        .game_win    (game_win)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       so;
        logic [1:0] num;
        int         tl;
        logic       bz, ov, wn;
    } exp_t;

    typedef struct {
        logic       s, c, f;
        int         n;
        logic       so;
        logic [1:0] num;
        int         tl;
        logic       bz, ov, wn;
    } vec_t;

    exp_t   sb[$];
    int     n_chk = 0, n_fail = 0;
    state_t m_st;
    int     m_num, m_tl, m_dw;

    task automatic check(input string name);
        exp_t e;
        logic [7:0] etl;
        e   = sb.pop_front();
        etl = e.tl[7:0];
        n_chk++;
        if (stageon !== e.so || stage_num !== e.num || (e.tl >= 0 && time_left !== etl) ||
            busy !== e.bz || game_over !== e.ov || game_win !== e.wn) begin
            n_fail++;
            $display("FAIL %s: got so=%0b num=%0d tl=%0d busy=%0b over=%0b win=%0b, want so=%0b num=%0d tl=%0d busy=%0b over=%0b win=%0b",
                     name, stageon, stage_num, time_left, busy, game_over, game_win,
                     e.so, e.num, e.tl, e.bz, e.ov, e.wn);
        end
    endtask

    task automatic m_reset();
        m_st = S_IDLE; m_num = 0; m_tl = 0; m_dw = 0;
    endtask

    // reference behaviour: one clock edge with the given inputs
    task automatic m_step(input logic s, input logic c, input logic f);
        case (m_st)
            S_LOAD: begin
                m_dw--;
                if (m_dw == 0) begin m_st = S_PLAY; m_tl = 100; end
            end
            S_PLAY: begin
                if (f) m_st = S_OVER;
                else if (c) begin m_st = S_CLEARED; m_dw = 4; end
                else if (m_tl == 1) begin m_st = S_OVER; m_tl = 0; end
                else m_tl--;
            end
            S_CLEARED: begin
                m_dw--;
                if (m_dw == 0 && m_num == 3) m_st = S_WIN;
                else if (m_dw == 0) begin m_num++; m_st = S_LOAD; m_dw = 2; end
            end
            default: if (s) begin m_st = S_LOAD; m_num = 0; m_dw = 2; end
        endcase
    endtask

    function automatic exp_t m_exp();
        exp_t e;
        e.so  = m_st inside {S_PLAY, S_CLEARED, S_OVER, S_WIN};
        e.num = 2'(m_num);
        e.tl  = (m_st == S_LOAD) ? -1 : m_tl;
        e.bz  = m_st inside {S_LOAD, S_PLAY, S_CLEARED};
        e.ov  = m_st == S_OVER;
        e.wn  = m_st == S_WIN;
        return e;
    endfunction

    task automatic drive(input logic s, input logic c, input logic f);
        start = s; stage_clear = c; stage_fail = f;
        m_step(s, c, f);
        @(posedge clock);
        #1;
        start = 1'b0; stage_clear = 1'b0; stage_fail = 1'b0;
    endtask

    task automatic cyc(input logic s, input logic c, input logic f, input string name);
        start = s;
        m_step(s, c, f);
        sb.push_back(m_exp());
        start = s; stage_clear = c; stage_fail = f;
        @(posedge clock);
        #1;
        start = 1'b0; stage_clear = 1'b0; stage_fail = 1'b0;
        check(name);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, want finish before 1ms");
        $fatal(1);
    end

    initial begin
        vec_t vt[15];
        exp_t z;
        int   lows;
        z = '{1'b0, 2'd0, 0, 1'b0, 1'b0, 1'b0};
        //        s  c  f   n   so num  tl  bz ov wn
        vt[0]  = '{1, 0, 0,  1, 0, 0,  -1, 1, 0, 0};
        vt[1]  = '{0, 0, 0,  1, 0, 0,  -1, 1, 0, 0};
        vt[2]  = '{0, 0, 0,  1, 1, 0, 100, 1, 0, 0};
        vt[3]  = '{0, 0, 0, 99, 1, 0,   1, 1, 0, 0};
        vt[4]  = '{0, 0, 0,  1, 1, 0,   0, 0, 1, 0};
        vt[5]  = '{0, 0, 0,  5, 1, 0,   0, 0, 1, 0};
        vt[6]  = '{1, 0, 0,  1, 0, 0,  -1, 1, 0, 0};
        vt[7]  = '{0, 0, 0,  2, 1, 0, 100, 1, 0, 0};
        vt[8]  = '{0, 0, 0, 10, 1, 0,  90, 1, 0, 0};
        vt[9]  = '{0, 1, 1,  1, 1, 0,  90, 0, 1, 0};
        vt[10] = '{1, 0, 0,  3, 1, 0, 100, 1, 0, 0};
        vt[11] = '{0, 0, 0, 99, 1, 0,   1, 1, 0, 0};
        vt[12] = '{0, 1, 0,  1, 1, 0,   1, 1, 0, 0};
        vt[13] = '{0, 0, 0,  3, 1, 0,   1, 1, 0, 0};
        vt[14] = '{0, 0, 0,  1, 0, 1,  -1, 1, 0, 0};

        m_reset();
        repeat (2) @(posedge clock);
        #1;
        sb.push_back(z);
        check("reset_state");
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        cyc(0, 0, 0, "idle");

        // timeout, clear+fail priority, clear on the last timer tick, restart from OVER
        foreach (vt[i]) begin
            sb.push_back('{vt[i].so, vt[i].num, vt[i].tl, vt[i].bz, vt[i].ov, vt[i].wn});
            drive(vt[i].s, vt[i].c, vt[i].f);
            for (int k = 1; k < vt[i].n; k++) drive(0, 0, 0);
            check($sformatf("vec%0d", i));
        end

        // now in LOAD of stage 1: start ignored in PLAY, CLEARED and LOAD
        repeat (2) cyc(0, 0, 0, "s1_load");
        cyc(1, 0, 0, "start_in_play");
        repeat (8) cyc(0, 0, 0, "s1_play");
        cyc(0, 1, 0, "s1_clear");
        cyc(1, 0, 0, "start_in_cleared");
        repeat (3) cyc(0, 0, 0, "s1_hold");
        cyc(1, 0, 0, "start_in_load");
        cyc(0, 0, 0, "s2_load");
        repeat (43) cyc(0, 0, 0, "s2_play");

        // asynchronous reset mid-PLAY at stage 2, time_left 57
        #2;
        reset = 1'b0;
        #1;
        m_reset();
        sb.push_back(z);
        check("async_reset_immediate");
        @(posedge clock);
        #1;
        sb.push_back(z);
        check("async_reset_held");
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        cyc(0, 0, 0, "post_reset_idle");

        // full game: clear on the 10th PLAY cycle of every stage
        lows = 0;
        cyc(1, 0, 0, "game_start");
        if (stageon === 1'b0) lows++;
        for (int s = 0; s < 4; s++) begin
            cyc(0, 0, 0, "game_load");
            if (stageon === 1'b0) lows++;
            repeat (10) cyc(0, 0, 0, "game_play");
            cyc(0, 1, 0, "game_clear");
            repeat (4) begin
                cyc(0, 0, 0, "game_hold");
                if (stageon === 1'b0) lows++;
            end
        end
        n_chk++;
        if (lows != 8) begin
            n_fail++;
            $display("FAIL load_low_cycles: got %0d, want 8", lows);
        end
        n_chk++;
        if (game_win !== 1'b1) begin
            n_fail++;
            $display("FAIL game_won: got %0b, want 1", game_win);
        end
        repeat (3) cyc(0, 0, 0, "win_sticky");
        cyc(1, 0, 0, "restart_from_win");
        cyc(0, 0, 0, "restart_load");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
